// File: rtl/watchdog_timer_if.sv
// Register bus for the watchdog timer.
// One write port and a combinational read port.
interface watchdog_timer_if;
    logic        WrEn;
    logic [1:0]  Addr;
    logic [31:0] WrData;
    logic [31:0] RdData;

    modport master (
        output WrEn,
        output Addr,
        output WrData,
        input  RdData
    );

    modport slave (
        input  WrEn,
        input  Addr,
        input  WrData,
        output RdData
    );
endinterface

// File: rtl/watchdog_timer.sv
// Watchdog timer: COUNT -> WARN (Irq) -> BITE (AutoRstReq pulse).
// Keyed kicks restart the count; a wrong key bites immediately.
module watchdog_timer #(
    parameter int          CNT_W    = 24,
    parameter logic [31:0] KICK_KEY = 32'h5A5AA5A5,
    parameter int          BITE_LEN = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    watchdog_timer_if.slave   bus,
    output logic              Irq,
    output logic              AutoRstReq
);

    localparam int BW = (BITE_LEN > 1) ? $clog2(BITE_LEN) : 1;
    localparam logic [BW-1:0] BITE_LAST = BW'(BITE_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_t;

    state_t           state;
    state_t           state_nxt;
    cnt_op_t          cnt_op;
    logic             set_pend;
    logic             bite_end;
    logic [1:0]       cause_nxt;

    logic             en;
    logic             irqen;
    logic             lock;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] cnt;
    logic             irq_pend;
    logic [1:0]       cause;
    logic [BW-1:0]    bite_cnt;

    logic             running;
    logic             wr_ok;
    logic             ctrl_wr;
    logic             load_wr;
    logic             kick_wr;
    logic             stat_wr;
    logic             kick_good;
    logic             kick_bad;
    logic             en_on;
    logic             en_off;
    logic             cnt_zero;
    logic [CNT_W-1:0] load_val;
    logic [23:0]      cnt_field;

    assign running   = (state == COUNT) || (state == WARN);
    assign wr_ok     = bus.WrEn && (state != BITE);
    assign ctrl_wr   = wr_ok && (bus.Addr == 2'd0) && !lock;
    assign load_wr   = wr_ok && (bus.Addr == 2'd1) && !lock;
    assign kick_wr   = wr_ok && (bus.Addr == 2'd2) && running;
    assign stat_wr   = wr_ok && (bus.Addr == 2'd3);
    assign kick_good = kick_wr && (bus.WrData == KICK_KEY);
    assign kick_bad  = kick_wr && (bus.WrData != KICK_KEY);
    assign en_on     = ctrl_wr && bus.WrData[0] && !en;
    assign en_off    = ctrl_wr && !bus.WrData[0] && en;
    assign cnt_zero  = (cnt == '0);
    assign cnt_field = 24'(cnt);

    // A zero reload would never expire cleanly, so it is stored as 1.
    assign load_val = (bus.WrData[CNT_W-1:0] == '0) ?
                      CNT_W'(1) : bus.WrData[CNT_W-1:0];

    assign Irq = irq_pend & irqen;

    // State register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; disable beats kick beats expiry.
    always_comb begin
        state_nxt = state;
        cnt_op    = CNT_HOLD;
        set_pend  = 1'b0;
        bite_end  = 1'b0;
        cause_nxt = cause;
        case (state)
            IDLE: begin
                if (en_on) begin
                    state_nxt = COUNT;
                    cnt_op    = CNT_LOAD;
                end
            end
            COUNT: begin
                if (en_off) begin
                    state_nxt = IDLE;
                end else if (kick_bad) begin
                    state_nxt = BITE;
                    cause_nxt = 2'b10;
                end else if (kick_good) begin
                    cnt_op = CNT_LOAD;
                end else if (cnt_zero) begin
                    state_nxt = WARN;
                    cnt_op    = CNT_LOAD;
                    set_pend  = 1'b1;
                end else begin
                    cnt_op = CNT_DEC;
                end
            end
            WARN: begin
                if (en_off) begin
                    state_nxt = IDLE;
                end else if (kick_bad) begin
                    state_nxt = BITE;
                    cause_nxt = 2'b10;
                end else if (kick_good) begin
                    state_nxt = COUNT;
                    cnt_op    = CNT_LOAD;
                end else if (cnt_zero) begin
                    state_nxt = BITE;
                    cause_nxt = 2'b01;
                end else begin
                    cnt_op = CNT_DEC;
                end
            end
            BITE: begin
                if (bite_cnt == BITE_LAST) begin
                    state_nxt = IDLE;
                    bite_end  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registers, counters and the registered reset request.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            en         <= 1'b0;
            irqen      <= 1'b0;
            lock       <= 1'b0;
            load       <= '1;
            cnt        <= '0;
            irq_pend   <= 1'b0;
            cause      <= 2'b00;
            bite_cnt   <= '0;
            AutoRstReq <= 1'b0;
        end else begin
            cause <= cause_nxt;
            case (cnt_op)
                CNT_LOAD: cnt <= load;
                CNT_DEC:  cnt <= cnt - CNT_W'(1);
                default:  cnt <= cnt;
            endcase
            if (ctrl_wr) begin
                en    <= bus.WrData[0];
                irqen <= bus.WrData[1];
                lock  <= bus.WrData[2];
            end else if (bite_end) begin
                en <= 1'b0;
            end
            if (load_wr) load <= load_val;
            if (set_pend)
                irq_pend <= 1'b1;
            else if (stat_wr && bus.WrData[24])
                irq_pend <= 1'b0;
            if ((state == BITE) && (state_nxt == BITE))
                bite_cnt <= bite_cnt + BW'(1);
            else
                bite_cnt <= '0;
            AutoRstReq <= (state_nxt == BITE);
        end
    end

    // Combinational register read.
    always_comb begin
        bus.RdData = '0;
        case (bus.Addr)
            2'd0: bus.RdData = {29'd0, lock, irqen, en};
            2'd1: bus.RdData = 32'(load);
            2'd2: bus.RdData = '0;
            2'd3: bus.RdData = {4'd0, (state != IDLE), cause,
                                irq_pend, cnt_field};
            default: bus.RdData = '0;
        endcase
    end

endmodule

// File: doc/watchdog_timer.md
WATCHDOG_TIMER -- requirements
Module: watchdog_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 24, giving the counter and LOAD width.
REQ-002 SHALL have parameter KICK_KEY, default 32'h5A5AA5A5, giving the valid kick value.
REQ-003 SHALL have parameter BITE_LEN, default 8, giving the number of AutoRstReq high cycles per bite.
REQ-004 SHALL have port Clock, input, 1 bit: system clock.
REQ-005 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-low (power-on only; not driven by AutoRstReq).
REQ-006 SHALL have port WrEn, input, 1 bit: register write strobe.
REQ-007 SHALL have port Addr, input, 2 bits: register select (0 CTRL, 1 LOAD, 2 KICK, 3 STATUS).
REQ-008 SHALL have port WrData, input, 32 bits: write data.
REQ-009 SHALL have port RdData, output, 32 bits: combinational read of the register at Addr.
REQ-010 SHALL have port Irq, output, 1 bit: pre-timeout warning, Irq = IrqPend & IRQEN.
REQ-011 SHALL have port AutoRstReq, output, 1 bit: registered reset request to the downstream auto-reset generator; it is rising-edge consumed there.

Function
REQ-012 SHALL define CTRL as: bit0 EN, bit1 IRQEN, bit2 LOCK; LOCK is sticky (write-1-to-set).
REQ-013 SHALL load LOAD from WrData[CNT_W-1:0]; a written value of 0 SHALL be stored as 1.
REQ-014 SHALL define STATUS reads as: [23:0] counter, [24] IrqPend, [26:25] Cause (01 timeout, 10 bad key), [27] Busy (state != IDLE), other bits 0.
REQ-015 SHALL clear IrqPend when STATUS is written with bit24 = 1; Cause SHALL be cleared only by Reset.
REQ-016 SHALL implement states IDLE, COUNT, WARN and BITE.
REQ-017 IDLE: an EN 0->1 write SHALL load counter = LOAD and enter COUNT on the same edge.
REQ-018 COUNT: counter != 0 -> decrement by 1; counter == 0 -> reload LOAD, set IrqPend, enter WARN.
REQ-019 WARN: counter != 0 -> decrement by 1; counter == 0 -> set Cause = 01 and enter BITE.
REQ-020 A KICK write of KICK_KEY in COUNT or WARN SHALL reload LOAD and enter COUNT; it SHALL NOT clear IrqPend.
REQ-021 A KICK write of any other value in COUNT or WARN SHALL set Cause = 10 and enter BITE on the next edge.
REQ-022 A KICK write in IDLE or BITE SHALL be ignored.
REQ-023 BITE: AutoRstReq SHALL be 1 for exactly BITE_LEN cycles, then the block SHALL enter IDLE with EN cleared (LOCK is retained).
REQ-024 All register writes SHALL be ignored during BITE.
REQ-025 With LOCK = 1, CTRL and LOAD writes SHALL be ignored; KICK and STATUS writes remain active.
REQ-026 An EN 1->0 write (unlocked) in COUNT or WARN SHALL enter IDLE and SHALL have priority over a same-cycle expiry.
REQ-027 A valid kick SHALL have priority over a same-cycle WARN expiry.
REQ-028 A LOAD write during COUNT or WARN SHALL NOT alter the running counter; it applies at the next reload.
REQ-029 Every write SHALL take effect at the edge ending its WrEn cycle.
REQ-030 AutoRstReq SHALL be 0 in all states except BITE.

Reset
REQ-031 On Reset low, asynchronously: state IDLE, EN = IRQEN = LOCK = 0, LOAD = all ones, counter = 0, IrqPend = 0, Cause = 00, bite counter = 0, AutoRstReq = 0, Irq = 0.
REQ-032 Reset asserted mid-BITE SHALL drop AutoRstReq immediately.

Verification
REQ-033 Timeout: LOAD = 5, CTRL = 3 written at cycle 0 -> COUNT in cycles 1-6, WARN and Irq = 1 from cycle 7, AutoRstReq = 1 in cycles 13-20, IDLE with Cause = 01 and EN = 0 at cycle 21.
REQ-034 Kick: same setup, KICK 0x5A5AA5A5 written at cycle 9 -> STATUS reads counter = 5 in cycle 10, Irq stays 1, AutoRstReq = 0; a STATUS write of 0x01000000 drops Irq.
REQ-035 Bad key: KICK 0x12345678 written in COUNT -> AutoRstReq rises next cycle, stays high 8 cycles, Cause = 10.
REQ-036 Lock: write CTRL = 5, then CTRL = 0 and LOAD = 2 -> EN, LOCK and LOAD unchanged; the timeout still bites.
REQ-037 Priority: EN cleared in the cycle WARN counter == 0 -> IDLE, no AutoRstReq; a valid kick in that cycle -> COUNT with counter = LOAD.
REQ-038 Reset pulse in BITE cycle 3 -> AutoRstReq = 0 asynchronously, STATUS = 0 apart from the counter field, LOAD = 0xFFFFFF.
